// File: rtl/stack_sequencer_if.sv
// ---------------------------------------------------------------------------
// stack_sequencer_if
// Bundles the core-facing request/response signals and the 16-bit data
// memory port of the stack sequencer into one interface.
//
//   master modport (core + memory side, drives requests and read data):
//     start, op[1:0], pc_in[31:0], flags_in[2:0], mem_rdata[15:0] -> out
//     mem_addr, mem_wdata, mem_we, mem_re, busy, done,
//     pc_out, flags_out, sp, stack_err                          <- in
//   slave modport (the sequencer itself): directions mirrored.
// ---------------------------------------------------------------------------
interface stack_sequencer_if #(
  parameter int ADDR_W = 12
);

  logic              start;
  logic [1:0]        op;
  logic [31:0]       pc_in;
  logic [2:0]        flags_in;
  logic [15:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic              busy;
  logic              done;
  logic [31:0]       pc_out;
  logic [2:0]        flags_out;
  logic [ADDR_W-1:0] sp;
  logic              stack_err;

  modport master (
    output start, op, pc_in, flags_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy, done,
           pc_out, flags_out, sp, stack_err
  );

  modport slave (
    input  start, op, pc_in, flags_in, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy, done,
           pc_out, flags_out, sp, stack_err
  );

endinterface

// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
// Multi-cycle controller moving a 32-bit PC (and optionally 3-bit flags)
// between the core and a 16-bit data memory for CALL/RET/INT/RTI. It owns
// the stack pointer, issues one memory word per cycle and holds busy high
// until the transfer is finished.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - stack_sequencer_if.slave:
//            start/op/pc_in/flags_in  request (op: 00 push PC, 01 pop PC,
//                                      10 push PC+flags, 11 pop flags+PC)
//            mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  memory port
//            busy/done/pc_out/flags_out/sp/stack_err     status/results
//
// Optional feature: define STACK_GUARD_EN to reject pushes that would go
// below SP_MIN and pops that would go above SP_INIT. A rejected request
// jumps straight to FINISH with stack_err pulsed alongside done. Without
// the macro stack_err is tied low and sp wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module stack_sequencer #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF,
  parameter logic [ADDR_W-1:0] SP_MIN  = 12'h800
) (
  input logic               clk,
  input logic               rst,
  stack_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_F, POP_F, POP_LO, POP_HI, WAIT_RD, FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  state_t            r_prev;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] w_spPlus1;
  logic [31:0]       r_pc;
  logic [2:0]        r_flags;
  logic              r_withFlags;
  logic [15:0]       r_shLo;
  logic [2:0]        r_shF;
  logic [31:0]       r_pcOut;
  logic [2:0]        r_flagsOut;
  logic              w_guardFail;

  assign w_spPlus1 = r_sp + ADDR_W'(1);

`ifdef STACK_GUARD_EN
  logic              r_err;
  logic [ADDR_W+1:0] w_spExt;
  logic [ADDR_W+1:0] w_words;

  // The bound check is done two bits wider than the stack pointer so that
  // sp-n+1 and sp+n can never wrap and hide an out-of-range transfer.
  always_comb begin
    w_spExt     = {2'b00, r_sp};
    w_words     = bus.op[1] ? (ADDR_W+2)'(3) : (ADDR_W+2)'(2);
    w_guardFail = 1'b0;
    if (bus.op[0])
      w_guardFail = (w_spExt + w_words) > {2'b00, SP_INIT};
    else
      w_guardFail = (w_spExt + (ADDR_W+2)'(1)) < ({2'b00, SP_MIN} + w_words);
  end

  // The error flag is latched at the accepted start and only shown during
  // FINISH, so stack_err pulses in the same cycle as done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (r_state == IDLE && bus.start)
      r_err <= w_guardFail;
  end

  assign bus.stack_err = (r_state == FINISH) && r_err;
`else
  assign w_guardFail   = 1'b0;
  assign bus.stack_err = 1'b0;
`endif

  // State register. r_prev remembers which read was issued last cycle so
  // the returning word can be steered into the right shadow field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= IDLE;
    end else begin
      r_state <= w_next;
      r_prev  <= r_state;
    end
  end

  // Next-state and memory strobes. Pushes write at sp, pops read at sp+1;
  // every other state leaves the memory port idle with zeroed address/data.
  always_comb begin
    w_next        = r_state;
    bus.busy      = (r_state != IDLE);
    bus.done      = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_guardFail)
            w_next = FINISH;
          else if (bus.op[0])
            w_next = bus.op[1] ? POP_F : POP_LO;
          else
            w_next = PUSH_HI;
        end
      end
      PUSH_HI: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp;
        bus.mem_wdata = r_pc[31:16];
        w_next        = PUSH_LO;
      end
      PUSH_LO: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp;
        bus.mem_wdata = r_pc[15:0];
        w_next        = r_withFlags ? PUSH_F : FINISH;
      end
      PUSH_F: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp;
        bus.mem_wdata = {13'b0, r_flags};
        w_next        = FINISH;
      end
      POP_F: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = w_spPlus1;
        w_next       = POP_LO;
      end
      POP_LO: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = w_spPlus1;
        w_next       = POP_HI;
      end
      POP_HI: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = w_spPlus1;
        w_next       = WAIT_RD;
      end
      WAIT_RD: begin
        w_next = FINISH;
      end
      FINISH: begin
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: request capture at start, stack pointer stepping, and shadow
  // capture of returned words. The high PC word arrives during WAIT_RD and
  // is folded straight into pc_out on the edge into FINISH, so pc_out and
  // flags_out change exactly when done is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= SP_INIT;
      r_pc        <= '0;
      r_flags     <= '0;
      r_withFlags <= 1'b0;
      r_shLo      <= '0;
      r_shF       <= '0;
      r_pcOut     <= '0;
      r_flagsOut  <= '0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_pc        <= bus.pc_in;
        r_flags     <= bus.flags_in;
        r_withFlags <= bus.op[1];
      end
      case (r_state)
        PUSH_HI, PUSH_LO, PUSH_F: r_sp <= r_sp - ADDR_W'(1);
        POP_F, POP_LO, POP_HI:    r_sp <= w_spPlus1;
        default:                  r_sp <= r_sp;
      endcase
      case (r_prev)
        POP_F:   r_shF  <= bus.mem_rdata[2:0];
        POP_LO:  r_shLo <= bus.mem_rdata;
        default: r_shLo <= r_shLo;
      endcase
      if (r_state == WAIT_RD) begin
        r_pcOut <= {bus.mem_rdata, r_shLo};
        if (r_withFlags)
          r_flagsOut <= r_shF;
      end
    end
  end

  assign bus.sp        = r_sp;
  assign bus.pc_out    = r_pcOut;
  assign bus.flags_out = r_flagsOut;

endmodule
